rtc_bus_reader: RTL and testbench
=================================

Name: rtc_bus_reader

Overview:
- Upstream feeder for the VGA clock display: periodically sweeps the external RTC over its multiplexed address/data bus, reading time, date and timer registers.
- Publishes them as stable BCD bytes: hora, min, seg, dia, mes, year, hcrono, mcrono, scrono, plus fin_crono.
- Outputs update atomically once per sweep, so the display never shows a torn value.
- Yields the bus to a writer block through a req/grant handshake.

Parameters:
- PHASE_CYCLES, 4: clocks per bus phase (ADDR, GAP, READ, RECOV); minimum 1.
- REFRESH_CYCLES, 1000000: idle clocks between sweeps (10 ms at 100 MHz).

Ports:
- CLK  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- ad_in  in  8  RTC AD bus sampled value.
- ad_out  out  8  RTC AD bus drive value.
- ad_oe  out  1  1 = drive ad_out onto the bus.
- cs_n, rd_n, wr_n, a_d_n  out  1 each  RTC strobes, active-low.
- wr_req  in  1  writer requests the bus.
- gnt  out  1  bus granted to writer.
- hora, min, seg, dia, mes, year, hcrono, mcrono, scrono  out  8 each  committed BCD values.
- fin_crono  out  1  committed timer bytes all 0x00.
- upd  out  1  one-cycle pulse: new values committed.

Behaviour:
- Reset state (rst=0 at a CLK edge):
  - all 8-bit outputs 0x00; fin_crono, upd, gnt, ad_oe = 0.
  - cs_n, rd_n, wr_n, a_d_n = 1; ad_out = 0x00; FSM in IDLE with index 0.
  - Applies on the edge after rst falls, including mid-transaction; the partial sweep is discarded.
- FSM states: IDLE, ADDR, GAP, READ, RECOV, COMMIT, WAIT, GRANT.
- IDLE (1 cycle after reset release):
  - wr_req=1 -> GRANT; else -> ADDR, index 0.
- ADDR (P cycles):
  - cs_n=0, wr_n=0, a_d_n=0, ad_oe=1, ad_out=ADDR_TABLE[index].
- GAP (P cycles): all strobes 1, ad_oe=0 (bus turnaround).
- READ (P cycles):
  - cs_n=0, rd_n=0, a_d_n=1, ad_oe=0.
  - ad_in captured into shadow[index] on the last READ cycle only.
- RECOV (P cycles): all strobes 1. On exit, in priority order:
  - wr_req=1 -> GRANT, index+1 saved;
  - else index<8 -> ADDR, index+1;
  - else -> COMMIT.
- COMMIT (1 cycle):
  - all nine outputs load from shadow at the cycle end.
  - fin_crono = (shadow hcrono, mcrono, scrono all 0x00).
  - upd=1 in the following cycle (the first WAIT cycle), aligned with the new values.
- WAIT (REFRESH_CYCLES cycles), exit in priority order:
  - wr_req=1 at any cycle -> GRANT immediately; the resume target is a fresh sweep from index 0.
  - else, on counter expiry -> ADDR, index 0.
- GRANT:
  - gnt=1; strobes 1; ad_oe=0.
  - Hold while wr_req=1; on wr_req=0, gnt drops and the FSM goes to ADDR at the saved index.
- Writer protocol: wr_req is never honoured inside a transaction; latency from wr_req rise to gnt is at most 4P+1 cycles.
- Sweep order and addresses (index 0..8):
  - seg 0x21, min 0x22, hora 0x23, dia 0x24, mes 0x25, year 0x26, scrono 0x41, mcrono 0x42, hcrono 0x43.
- Timing:
  - Sweep length = 36*P cycles, then COMMIT (1 cycle).
  - upd period with no grants = 36*P + 1 + REFRESH_CYCLES.
  - Phase and refresh counters are sized by $clog2 of their parameter and saturate-free; they reload on every state entry.
- Outputs hold between commits; shadow contents are never visible directly.
- Values are passed through unchecked (no BCD validation).

Decomposition:
- Package rtc_pkg holds:
  - state enum;
  - ADDR_TABLE (9 x 8-bit) and NUM_REGS=9;
  - register index constants (IDX_SEG ... IDX_HCRONO).
- One natural sub-module: rtc_phase_timer. A loadable down-counter giving a phase-done strobe, reused for the PHASE and REFRESH counts.

Test Plan:
- Reset/first sweep. With P=2, R=100, release rst.
  - All outputs 0x00 and strobes 1 during reset.
  - IDLE for 1 cycle, then ADDR with ad_out=0x21, ad_oe=1, cs_n=wr_n=a_d_n=0 for exactly 2 cycles.
- Full sweep. RTC model returns seg 0x59, min 0x34, hora 0x12, dia 0x31, mes 0x12, year 0x16, timer 0x05/0x00/0x01.
  - upd fires 73 cycles after the first ADDR, and all outputs match.
  - No output changes before upd.
  - fin_crono=0.
- Refresh period. With no wr_req, consecutive upd pulses are exactly 173 cycles apart.
  - Change the model's seg to 0x00; the next commit shows seg=0x00.
- Grant mid-sweep. Raise wr_req during READ of min (index 1).
  - The min transaction completes, and gnt=1 the cycle after RECOV ends.
  - Strobes stay idle while granted.
  - Drop wr_req; gnt=0 and the next ADDR carries 0x23.
- fin_crono. Timer regs all 0x00 -> fin_crono=1 together with upd.
  - Next sweep with scrono=0x01 -> fin_crono=0.
- Reset mid-READ. Assert rst during READ of dia.
  - Next edge: outputs 0x00, strobes 1.
  - After release, the sweep restarts at address 0x21.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus reader: FSM states, register
// indices and the bus address of each register in sweep order.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_GAP    = 3'd2,
        ST_READ   = 3'd3,
        ST_RECOV  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_WAIT   = 3'd6,
        ST_GRANT  = 3'd7
    } state_e;

    localparam logic [3:0] NUM_REGS = 4'd9;

    localparam logic [3:0] IDX_SEG    = 4'd0;
    localparam logic [3:0] IDX_MIN    = 4'd1;
    localparam logic [3:0] IDX_HORA   = 4'd2;
    localparam logic [3:0] IDX_DIA    = 4'd3;
    localparam logic [3:0] IDX_MES    = 4'd4;
    localparam logic [3:0] IDX_YEAR   = 4'd5;
    localparam logic [3:0] IDX_SCRONO = 4'd6;
    localparam logic [3:0] IDX_MCRONO = 4'd7;
    localparam logic [3:0] IDX_HCRONO = 4'd8;

    // Entry 0 sits in the least significant byte.
    localparam logic [8:0][7:0] ADDR_TABLE = {
        8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] a;
        if (idx < NUM_REGS) begin
            a = ADDR_TABLE[idx];
        end else begin
            a = 8'h00;
        end
        return a;
    endfunction

endpackage

// File: rtl/rtc_bus_reader_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a load
// of N-1 on state entry marks the N-th cycle of that state.
module rtc_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, else count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Sweeps the RTC over its multiplexed AD bus, buffers a full sweep in a shadow
// copy and commits it atomically; yields the bus to a writer between transactions.
module rtc_bus_reader
    import rtc_pkg::*;
#(
    parameter int PHASE_CYCLES   = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d_n,
    input  logic       wr_req,
    output logic       gnt,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] year,
    output logic [7:0] hcrono,
    output logic [7:0] mcrono,
    output logic [7:0] scrono,
    output logic       fin_crono,
    output logic       upd
);

    localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LOAD   = PW'(PHASE_CYCLES - 1);
    localparam logic [RW-1:0] REFRESH_LOAD = RW'(REFRESH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [8:0][7:0] shadow_q, shadow_d;
    logic [8:0][7:0] out_q, out_d;
    logic            fin_crono_q, fin_crono_d;
    logic            upd_q, upd_d;
    logic            cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, a_d_n_q, a_d_n_d;
    logic            ad_oe_q, ad_oe_d, gnt_q, gnt_d;
    logic [7:0]      ad_out_q, ad_out_d;
    logic            timer_load, phase_done, refresh_done;

    assign timer_load = (state_d != state_q);

    rtc_phase_timer #(.W(PW)) u_phase_timer (
        .clk      (CLK),
        .rst      (rst),
        .load     (timer_load),
        .load_val (PHASE_LOAD),
        .done     (phase_done)
    );

    rtc_phase_timer #(.W(RW)) u_refresh_timer (
        .clk      (CLK),
        .rst      (rst),
        .load     (timer_load),
        .load_val (REFRESH_LOAD),
        .done     (refresh_done)
    );

    // Next state, register index (doubles as resume index while granted) and shadow capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                if (wr_req) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (phase_done) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_READ: begin
                if (phase_done) begin
                    shadow_d[idx_q] = ad_in;
                    state_d         = ST_RECOV;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RECOV: begin
                if (phase_done) begin
                    idx_d = idx_q + 4'd1;
                    if (wr_req) begin
                        state_d = ST_GRANT;
                    end else if (idx_q < IDX_HCRONO) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_RECOV;
                end
            end
            ST_COMMIT: begin
                idx_d   = 4'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                idx_d = 4'd0;
                if (wr_req) begin
                    state_d = ST_GRANT;
                end else if (refresh_done) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GRANT: begin
                // A grant taken after the last register resumes straight into the commit.
                if (wr_req) begin
                    state_d = ST_GRANT;
                end else if (idx_q >= NUM_REGS) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Bus strobes and grant, decoded from the next state so they line up with state_q.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_n_d  = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        gnt_d    = 1'b0;
        case (state_d)
            ST_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_n_d  = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = reg_addr(idx_d);
            end
            ST_READ: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            ST_GRANT: begin
                gnt_d = 1'b1;
            end
            default: begin
                gnt_d = 1'b0;
            end
        endcase
    end

    // Published values change only on COMMIT, so a display never sees a half-updated sweep.
    always_comb begin
        out_d       = out_q;
        fin_crono_d = fin_crono_q;
        upd_d       = 1'b0;
        if (state_q == ST_COMMIT) begin
            out_d       = shadow_q;
            fin_crono_d = (shadow_q[IDX_HCRONO] == 8'h00) &&
                          (shadow_q[IDX_MCRONO] == 8'h00) &&
                          (shadow_q[IDX_SCRONO] == 8'h00);
            upd_d       = 1'b1;
        end else begin
            upd_d = 1'b0;
        end
    end

    // All state and output registers; reset discards any partial sweep.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            shadow_q    <= '0;
            out_q       <= '0;
            fin_crono_q <= 1'b0;
            upd_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_d_n_q     <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= 8'h00;
            gnt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            fin_crono_q <= fin_crono_d;
            upd_q       <= upd_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            a_d_n_q     <= a_d_n_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            gnt_q       <= gnt_d;
        end
    end

    assign ad_out    = ad_out_q;
    assign ad_oe     = ad_oe_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign a_d_n     = a_d_n_q;
    assign gnt       = gnt_q;
    assign seg       = out_q[IDX_SEG];
    assign min       = out_q[IDX_MIN];
    assign hora      = out_q[IDX_HORA];
    assign dia       = out_q[IDX_DIA];
    assign mes       = out_q[IDX_MES];
    assign year      = out_q[IDX_YEAR];
    assign scrono    = out_q[IDX_SCRONO];
    assign mcrono    = out_q[IDX_MCRONO];
    assign hcrono    = out_q[IDX_HCRONO];
    assign fin_crono = fin_crono_q;
    assign upd       = upd_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Scoreboard bench for rtc_bus_reader: an RTC memory model answers bus reads,
// expected commits are queued at stimulus time and checked by a monitor on upd.
module tb_rtc_bus_reader;

    localparam int P = 2;
    localparam int R = 100;
    localparam int SWEEP = 36 * P;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ad_in, ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d_n, wr_req, gnt;
    logic [7:0] hora, min, seg, dia, mes, year, hcrono, mcrono, scrono;
    logic       fin_crono, upd;

    rtc_bus_reader #(.PHASE_CYCLES(P), .REFRESH_CYCLES(R)) dut (
        .CLK(CLK), .rst(rst), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d_n(a_d_n),
        .wr_req(wr_req), .gnt(gnt),
        .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .year(year),
        .hcrono(hcrono), .mcrono(mcrono), .scrono(scrono),
        .fin_crono(fin_crono), .upd(upd)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] hora, mn, seg, dia, mes, year, hc, mc, sc;
        logic       fin;
    } snap_t;

    logic [7:0] rtc_mem [256];
    logic [7:0] addr_lat = 8'h00;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    snap_t      exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // RTC model: latch address during the address phase, return register on read.
    always @(posedge CLK) if (!cs_n && !a_d_n && !wr_n) addr_lat <= ad_out;
    assign ad_in = (!cs_n && !rd_n) ? rtc_mem[addr_lat] : 8'hFF;

    function automatic snap_t model();
        snap_t s;
        s.seg  = rtc_mem[8'h21]; s.mn   = rtc_mem[8'h22]; s.hora = rtc_mem[8'h23];
        s.dia  = rtc_mem[8'h24]; s.mes  = rtc_mem[8'h25]; s.year = rtc_mem[8'h26];
        s.sc   = rtc_mem[8'h41]; s.mc   = rtc_mem[8'h42]; s.hc   = rtc_mem[8'h43];
        s.fin  = (s.hc == 8'h00) && (s.mc == 8'h00) && (s.sc == 8'h00);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.seg = seg; s.mn = min; s.hora = hora; s.dia = dia; s.mes = mes; s.year = year;
        s.sc = scrono; s.mc = mcrono; s.hc = hcrono; s.fin = fin_crono;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic wait_upd(output int at);
        at = -1;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (upd === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++; n_fail++;
            $display("FAIL upd_timeout: no upd within 1000 cycles");
        end
    endtask

    task automatic wait_read(input logic [7:0] a);
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (!cs_n && !rd_n && addr_lat == a) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL read_timeout: no read of %0h within 1000 cycles", a);
        end
    endtask

    task automatic randomize_regs();
        logic [7:0] addrs [9];
        addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        foreach (addrs[i]) rtc_mem[addrs[i]] = 8'($urandom);
    endtask

    // Monitor: on upd pop and compare; otherwise outputs must hold their committed values.
    initial begin
        snap_t held, got, e;
        held = '0;
        forever begin
            @(negedge CLK);
            if (!rst) begin
                held = '0;
            end else begin
                got = dut_snap();
                n_chk++;
                if (upd === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL commit: unexpected upd, got %h", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL commit: got %h expected %h", got, e);
                        end
                    end
                    held = got;
                end else if (got !== held) begin
                    n_fail++;
                    $display("FAIL hold: got %h expected %h (cycle %0d)", got, held, cyc);
                end
            end
        end
    end

    initial begin
        int t_addr, t_prev, t_now;
        snap_t e;
        wr_req = 1'b0;
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
        rtc_mem[8'h21] = 8'h59; rtc_mem[8'h22] = 8'h34; rtc_mem[8'h23] = 8'h12;
        rtc_mem[8'h24] = 8'h31; rtc_mem[8'h25] = 8'h12; rtc_mem[8'h26] = 8'h16;
        rtc_mem[8'h43] = 8'h05; rtc_mem[8'h42] = 8'h00; rtc_mem[8'h41] = 8'h01;

        // Reset state
        step(3);
        chk("reset_values", {dut_snap(), upd, gnt, ad_oe}, 32'h0);
        chk("reset_strobes", {cs_n, rd_n, wr_n, a_d_n}, 4'hF);
        chk("reset_ad_out", ad_out, 8'h00);

        // First sweep
        exp_q.push_back(model());
        rst = 1'b1;
        step(1);
        t_addr = cyc;
        chk("addr0_ad_out", ad_out, 8'h21);
        chk("addr0_ctrl", {ad_oe, cs_n, wr_n, a_d_n, rd_n}, 5'b10001);
        step(1);
        chk("addr0_hold", {ad_oe, cs_n, wr_n, a_d_n, rd_n}, 5'b10001);
        step(1);
        chk("gap_ctrl", {ad_oe, cs_n, wr_n, a_d_n, rd_n}, 5'b01111);
        wait_upd(t_now);
        chk("first_upd_latency", t_now - t_addr, SWEEP + 1);
        chk("first_fin_crono", fin_crono, 1'b0);
        t_prev = t_now;

        // Refresh periods with randomized contents and fin_crono corners
        for (int k = 0; k < 4; k++) begin
            randomize_regs();
            if (k == 0) rtc_mem[8'h21] = 8'h00;
            if (k == 1) begin
                rtc_mem[8'h41] = 8'h00; rtc_mem[8'h42] = 8'h00; rtc_mem[8'h43] = 8'h00;
            end
            if (k == 2) begin
                rtc_mem[8'h41] = 8'h01; rtc_mem[8'h42] = 8'h00; rtc_mem[8'h43] = 8'h00;
            end
            e = model();
            exp_q.push_back(e);
            wait_upd(t_now);
            chk("upd_period", t_now - t_prev, SWEEP + 1 + R);
            chk("fin_crono", fin_crono, e.fin);
            if (k == 0) chk("seg_zero", seg, 8'h00);
            t_prev = t_now;
        end

        // Grant requested during READ of min
        randomize_regs();
        exp_q.push_back(model());
        wait_read(8'h22);
        wr_req = 1'b1;
        for (int i = 0; i < 2 * P && rd_n == 1'b0; i++) step(1);
        chk("recov1_gnt", gnt, 1'b0);
        step(P - 1);
        chk("recov_last_gnt", gnt, 1'b0);
        step(1);
        chk("gnt_after_recov", gnt, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("granted_idle", {gnt, ad_oe, cs_n, rd_n, wr_n, a_d_n}, 6'b101111);
            step(1);
        end
        wr_req = 1'b0;
        step(1);
        chk("release_gnt", gnt, 1'b0);
        chk("resume_addr", ad_out, 8'h23);
        chk("resume_ctrl", {ad_oe, cs_n}, 2'b10);
        wait_upd(t_now);

        // Grant requested while waiting for the next refresh
        exp_q.push_back(model());
        wr_req = 1'b1;
        step(1);
        chk("wait_gnt", gnt, 1'b1);
        step(2);
        wr_req = 1'b0;
        step(1);
        chk("wait_release_gnt", gnt, 1'b0);
        chk("wait_resume_addr", ad_out, 8'h21);
        wait_upd(t_now);

        // Reset during READ of dia
        randomize_regs();
        exp_q.push_back(model());
        wait_read(8'h24);
        rst = 1'b0;
        step(1);
        chk("midreset_values", {dut_snap(), upd, gnt, ad_oe}, 32'h0);
        chk("midreset_strobes", {cs_n, rd_n, wr_n, a_d_n}, 4'hF);
        exp_q.delete();
        exp_q.push_back(model());
        step(2);
        rst = 1'b1;
        step(1);
        chk("restart_addr", ad_out, 8'h21);
        chk("restart_ctrl", {ad_oe, cs_n}, 2'b10);
        wait_upd(t_now);
        step(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
